// File: rtl/set_assoc_cache_if.sv
// Core request/response and backing-memory signals of the 2-way cache, bundled
// so the cache sees one slave view and the environment one master view.
interface set_assoc_cache_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit,
    output mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache.sv
// 2-way set-associative write-back / write-allocate L1 data cache with true-LRU
// replacement, single-cycle hits, and a stalling miss path over a req/ack memory port.
module set_assoc_cache #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  set_assoc_cache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WB, REFILL, RESP} state_t;

  state_t state_reg, state_next;

  // Tag/data are plain storage; valid/dirty/LRU need reset so they live in flops.
  logic [TAG_W-1:0]     tag_mem  [2][SETS];
  logic [DATA_W-1:0]    data_mem [2][SETS];
  logic [1:0][SETS-1:0] valid_reg;
  logic [1:0][SETS-1:0] dirty_reg;
  logic [SETS-1:0]      lru_reg;

  logic               miss_we_reg;
  logic [ADDR_W-1:0]  miss_addr_reg;
  logic [DATA_W-1:0]  miss_wdata_reg;
  logic               victim_way_reg;
  logic [TAG_W-1:0]   victim_tag_reg;
  logic [DATA_W-1:0]  victim_data_reg;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;

  logic               resp_valid_reg;
  logic               resp_hit_reg;
  logic [DATA_W-1:0]  resp_rdata_reg;
  logic [CNT_W-1:0]   hit_count_reg;
  logic [CNT_W-1:0]   miss_count_reg;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         way_hit;
  logic [TAG_W-1:0]   way_tag  [2];
  logic [DATA_W-1:0]  way_data [2];
  logic               lookup_hit;
  logic               hit_way;
  logic               victim_way;
  logic               victim_dirty;

  logic               req_ready;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               accept;
  logic               resp_set;
  logic               resp_hit_next;
  logic [DATA_W-1:0]  resp_rdata_next;
  logic               data_we;
  logic               meta_we;
  logic               meta_valid;
  logic               meta_dirty;
  logic               lru_we;
  logic               upd_way;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic [DATA_W-1:0]  upd_data;

  assign req_idx  = bus.req_addr[INDEX_W-1:0];
  assign req_tag  = bus.req_addr[ADDR_W-1:INDEX_W];
  assign miss_idx = miss_addr_reg[INDEX_W-1:0];
  assign miss_tag = miss_addr_reg[ADDR_W-1:INDEX_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign way_tag[gi]  = tag_mem[gi][req_idx];
      assign way_data[gi] = data_mem[gi][req_idx];
      assign way_hit[gi]  = valid_reg[gi][req_idx] && (way_tag[gi] == req_tag);
    end
  endgenerate

  assign lookup_hit = |way_hit;
  assign hit_way    = ~way_hit[0];

  // Fill invalid ways first (way 0 before way 1), otherwise evict the LRU way.
  always_comb begin
    if (!valid_reg[0][req_idx]) begin
      victim_way = 1'b0;
    end else if (!valid_reg[1][req_idx]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru_reg[req_idx];
    end
  end

  assign victim_dirty = valid_reg[victim_way][req_idx] && dirty_reg[victim_way][req_idx];

  always_comb begin
    state_next      = state_reg;
    req_ready       = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    accept          = 1'b0;
    resp_set        = 1'b0;
    resp_hit_next   = 1'b0;
    resp_rdata_next = '0;
    data_we         = 1'b0;
    meta_we         = 1'b0;
    meta_valid      = 1'b0;
    meta_dirty      = 1'b0;
    lru_we          = 1'b0;
    upd_way         = victim_way_reg;
    upd_idx         = miss_idx;
    upd_tag         = miss_tag;
    upd_data        = miss_wdata_reg;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          upd_idx  = req_idx;
          upd_tag  = req_tag;
          upd_data = bus.req_wdata;
          if (lookup_hit) begin
            upd_way       = hit_way;
            lru_we        = 1'b1;
            resp_set      = 1'b1;
            resp_hit_next = 1'b1;
            if (bus.req_we) begin
              data_we    = 1'b1;
              meta_we    = 1'b1;
              meta_valid = 1'b1;
              meta_dirty = 1'b1;
            end else begin
              resp_rdata_next = way_data[hit_way];
            end
          end else if (victim_dirty) begin
            state_next = WB;
          end else if (!bus.req_we) begin
            state_next = REFILL;
          end else begin
            // Clean write miss: the whole line is overwritten, so no refill.
            upd_way    = victim_way;
            data_we    = 1'b1;
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
            lru_we     = 1'b1;
            resp_set   = 1'b1;
            state_next = RESP;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_reg, miss_idx};
        mem_wdata = victim_data_reg;
        if (bus.mem_ack) begin
          meta_we = 1'b1;
          if (miss_we_reg) begin
            data_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
            lru_we     = 1'b1;
            resp_set   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = miss_addr_reg;
        if (bus.mem_ack) begin
          data_we         = 1'b1;
          upd_data        = bus.mem_rdata;
          meta_we         = 1'b1;
          meta_valid      = 1'b1;
          lru_we          = 1'b1;
          resp_set        = 1'b1;
          resp_rdata_next = bus.mem_rdata;
          state_next      = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && !rst) begin
      tag_mem[upd_way][upd_idx]  <= upd_tag;
      data_mem[upd_way][upd_idx] <= upd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
      lru_reg   <= '0;
    end else begin
      if (meta_we) begin
        valid_reg[upd_way][upd_idx] <= meta_valid;
        dirty_reg[upd_way][upd_idx] <= meta_dirty;
      end
      if (lru_we) begin
        lru_reg[upd_idx] <= ~upd_way;
      end
    end
  end

  // Victim tag/data are captured at acceptance so the memory bus stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_we_reg     <= 1'b0;
      miss_addr_reg   <= '0;
      miss_wdata_reg  <= '0;
      victim_way_reg  <= 1'b0;
      victim_tag_reg  <= '0;
      victim_data_reg <= '0;
    end else if (accept && !lookup_hit) begin
      miss_we_reg     <= bus.req_we;
      miss_addr_reg   <= bus.req_addr;
      miss_wdata_reg  <= bus.req_wdata;
      victim_way_reg  <= victim_way;
      victim_tag_reg  <= way_tag[victim_way];
      victim_data_reg <= way_data[victim_way];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      resp_valid_reg <= resp_set;
      resp_hit_reg   <= resp_hit_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept && lookup_hit && (hit_count_reg != CNT_MAX)) begin
        hit_count_reg <= hit_count_reg + CNT_ONE;
      end
      if (accept && !lookup_hit && (miss_count_reg != CNT_MAX)) begin
        miss_count_reg <= miss_count_reg + CNT_ONE;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_hit   = resp_hit_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: a vector table of single requests with a
// backing-memory responder, plus hand sequences for back-to-back hits and reset mid-writeback.
module tb_set_assoc_cache;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 8;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  set_assoc_cache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    logic        exp_wb;
    logic [16:0] wb_addr;
    logic [31:0] wb_data;
    logic        exp_rf;
    logic [16:0] rf_addr;
    int          exp_h;
    int          exp_m;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] backing [int];

  int n_cmp = 0;
  int n_bad = 0;

  logic        r_accept_ready;
  logic        r_resp;
  logic        r_hit;
  logic [31:0] r_rdata;
  logic        r_lat_ok;
  logic        r_stable;
  logic        r_ready_ok;
  int          r_wb;
  logic [16:0] r_wb_addr;
  logic [31:0] r_wb_data;
  int          r_rf;
  logic [16:0] r_rf_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [16:0] a);
    if (backing.exists(int'(a))) return backing[int'(a)];
    return 32'h1000_0000 | {15'd0, a};
  endfunction

  // Issues one request, then plays the memory side until the response pulse.
  task automatic run_txn(input logic we, input logic [16:0] addr, input logic [31:0] wdata,
                         input int delay);
    int          wcnt;
    int          last_ack;
    logic        cur_we;
    logic [16:0] cur_addr;
    logic [31:0] cur_wdata;
    r_resp = 1'b0; r_hit = 1'b0; r_rdata = '0; r_lat_ok = 1'b0;
    r_stable = 1'b1; r_ready_ok = 1'b1; r_wb = 0; r_rf = 0;
    r_wb_addr = '0; r_wb_data = '0; r_rf_addr = '0;
    cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
    @(negedge clk);
    r_accept_ready = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    wcnt = 0;
    last_ack = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.mem_ack = 1'b0;
      if (bus.resp_valid) begin
        r_resp   = 1'b1;
        r_hit    = bus.resp_hit;
        r_rdata  = bus.resp_rdata;
        r_lat_ok = (cyc == last_ack + 1);
        break;
      end
      if (bus.req_ready) r_ready_ok = 1'b0;
      if (bus.mem_req) begin
        if (wcnt == 0) begin
          cur_we = bus.mem_we; cur_addr = bus.mem_addr; cur_wdata = bus.mem_wdata;
          if (cur_we) begin
            r_wb++; r_wb_addr = cur_addr; r_wb_data = cur_wdata;
            backing[int'(cur_addr)] = cur_wdata;
          end else begin
            r_rf++; r_rf_addr = cur_addr;
          end
        end else if (bus.mem_we !== cur_we || bus.mem_addr !== cur_addr ||
                     (cur_we && bus.mem_wdata !== cur_wdata)) begin
          r_stable = 1'b0;
        end
        if (wcnt == delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur_we ? 32'h0 : mem_read(cur_addr);
          wcnt = 0;
          last_ack = cyc;
        end else begin
          wcnt++;
        end
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    run_txn(v.we, v.addr, v.wdata, v.delay);
    $display("vec %0d: %s addr=%0d -> resp=%0b hit=%0b rdata=%0h wb=%0d rf=%0d hits=%0d misses=%0d",
             i, v.we ? "W" : "R", v.addr, r_resp, r_hit, r_rdata, r_wb, r_rf,
             bus.hit_count, bus.miss_count);
    check($sformatf("v%0d req_ready", i), r_accept_ready, 1);
    check($sformatf("v%0d resp_seen", i), r_resp, 1);
    check($sformatf("v%0d resp_hit", i), r_hit, v.exp_hit);
    check($sformatf("v%0d resp_rdata", i), r_rdata, v.exp_rdata);
    check($sformatf("v%0d latency", i), r_lat_ok, 1);
    check($sformatf("v%0d stall_ready", i), r_ready_ok, 1);
    check($sformatf("v%0d mem_stable", i), r_stable, 1);
    check($sformatf("v%0d wb_count", i), r_wb, v.exp_wb ? 1 : 0);
    if (v.exp_wb) begin
      check($sformatf("v%0d wb_addr", i), r_wb_addr, v.wb_addr);
      check($sformatf("v%0d wb_data", i), r_wb_data, v.wb_data);
    end
    check($sformatf("v%0d refill_count", i), r_rf, v.exp_rf ? 1 : 0);
    if (v.exp_rf) check($sformatf("v%0d refill_addr", i), r_rf_addr, v.rf_addr);
    check($sformatf("v%0d hit_count", i), bus.hit_count, v.exp_h);
    check($sformatf("v%0d miss_count", i), bus.miss_count, v.exp_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    addr     wdata     dly hit  rdata          wb    wb_addr  wb_data   rf    rf_addr  h  m
    vecs[0]  = '{1'b0, 17'd1,   32'd0,     0, 1'b0, 32'h1000_0001, 1'b0, 17'd0,   32'd0,     1'b1, 17'd1,   0, 1};
    vecs[1]  = '{1'b1, 17'd3,   32'd432,   0, 1'b0, 32'd0,         1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   0, 2};
    vecs[2]  = '{1'b0, 17'd3,   32'd0,     0, 1'b1, 32'd432,       1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   1, 2};
    vecs[3]  = '{1'b1, 17'd259, 32'd870,   0, 1'b0, 32'd0,         1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   1, 3};
    vecs[4]  = '{1'b0, 17'd3,   32'd0,     0, 1'b1, 32'd432,       1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   2, 3};
    vecs[5]  = '{1'b1, 17'd515, 32'd45687, 1, 1'b0, 32'd0,         1'b1, 17'd259, 32'd870,   1'b0, 17'd0,   2, 4};
    vecs[6]  = '{1'b0, 17'd3,   32'd0,     0, 1'b1, 32'd432,       1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   3, 4};
    vecs[7]  = '{1'b0, 17'd259, 32'd0,     2, 1'b0, 32'd870,       1'b1, 17'd515, 32'd45687, 1'b1, 17'd259, 3, 5};
    vecs[8]  = '{1'b0, 17'd515, 32'd0,     0, 1'b0, 32'd45687,     1'b1, 17'd3,   32'd432,   1'b1, 17'd515, 3, 6};
    vecs[9]  = '{1'b1, 17'd259, 32'd999,   0, 1'b1, 32'd0,         1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   4, 6};
    vecs[10] = '{1'b0, 17'd259, 32'd0,     0, 1'b1, 32'd999,       1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   5, 6};
    vecs[11] = '{1'b0, 17'd1,   32'd0,     0, 1'b1, 32'h1000_0001, 1'b0, 17'd0,   32'd0,     1'b0, 17'd0,   6, 6};
    vecs[12] = '{1'b0, 17'd771, 32'd0,     5, 1'b0, 32'h1000_0303, 1'b0, 17'd0,   32'd0,     1'b1, 17'd771, 6, 7};
    // Applied after the reset-during-writeback sequence.
    vecs[13] = '{1'b0, 17'd259, 32'd0,     1, 1'b0, 32'd870,       1'b0, 17'd0,   32'd0,     1'b1, 17'd259, 0, 1};
    vecs[14] = '{1'b0, 17'd1,   32'd0,     0, 1'b0, 32'h1000_0001, 1'b0, 17'd0,   32'd0,     1'b1, 17'd1,   0, 2};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: req_ready=%0b resp_valid=%0b mem_req=%0b hits=%0d misses=%0d",
             bus.req_ready, bus.resp_valid, bus.mem_req, bus.hit_count, bus.miss_count);
    check("rst req_ready", bus.req_ready, 1);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst resp_hit", bus.resp_hit, 0);
    check("rst resp_rdata", bus.resp_rdata, 0);
    check("rst mem_req", bus.mem_req, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    check("rst hit_count", bus.hit_count, 0);
    check("rst miss_count", bus.miss_count, 0);

    for (int i = 0; i <= 12; i++) apply_vec(i);

    // Back-to-back: write hit 259, read 259 next cycle, read 771 next cycle.
    @(negedge clk);
    check("b2b ready0", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 17'd259; bus.req_wdata = 32'd1234;
    @(negedge clk);
    $display("b2b write 259: resp_valid=%0b hit=%0b rdata=%0h", bus.resp_valid, bus.resp_hit, bus.resp_rdata);
    check("b2b w resp_valid", bus.resp_valid, 1);
    check("b2b w resp_hit", bus.resp_hit, 1);
    check("b2b w resp_rdata", bus.resp_rdata, 0);
    check("b2b ready1", bus.req_ready, 1);
    bus.req_we = 1'b0; bus.req_addr = 17'd259; bus.req_wdata = '0;
    @(negedge clk);
    $display("b2b read 259: resp_valid=%0b hit=%0b rdata=%0h", bus.resp_valid, bus.resp_hit, bus.resp_rdata);
    check("b2b raw resp_valid", bus.resp_valid, 1);
    check("b2b raw resp_hit", bus.resp_hit, 1);
    check("b2b raw resp_rdata", bus.resp_rdata, 32'd1234);
    check("b2b ready2", bus.req_ready, 1);
    bus.req_addr = 17'd771;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = '0;
    $display("b2b read 771: resp_valid=%0b hit=%0b rdata=%0h", bus.resp_valid, bus.resp_hit, bus.resp_rdata);
    check("b2b r771 resp_valid", bus.resp_valid, 1);
    check("b2b r771 resp_hit", bus.resp_hit, 1);
    check("b2b r771 resp_rdata", bus.resp_rdata, 32'h1000_0303);
    @(negedge clk);
    check("b2b idle resp_valid", bus.resp_valid, 0);
    check("b2b hit_count", bus.hit_count, 9);
    check("b2b miss_count", bus.miss_count, 7);

    // Read 1283 (set 3, tag 5) evicts dirty 259; reset lands while in writeback.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 17'd1283;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = '0;
    $display("wb before reset: mem_req=%0b mem_we=%0b mem_addr=%0d mem_wdata=%0d",
             bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    check("wbrst mem_req", bus.mem_req, 1);
    check("wbrst mem_we", bus.mem_we, 1);
    check("wbrst mem_addr", bus.mem_addr, 17'd259);
    check("wbrst mem_wdata", bus.mem_wdata, 32'd1234);
    check("wbrst req_ready", bus.req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("after reset: mem_req=%0b req_ready=%0b hits=%0d misses=%0d",
             bus.mem_req, bus.req_ready, bus.hit_count, bus.miss_count);
    check("wbrst mem_req after", bus.mem_req, 0);
    check("wbrst req_ready after", bus.req_ready, 1);
    check("wbrst resp_valid after", bus.resp_valid, 0);
    check("wbrst hit_count after", bus.hit_count, 0);
    check("wbrst miss_count after", bus.miss_count, 0);

    apply_vec(13);
    apply_vec(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
